// File: rtl/fir_stream_pkg.sv
// Shared types and constants for the FIR sample source.
`timescale 1ns/1ps
package fir_stream_pkg;

    localparam int DATA_W = 6;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_IMPULSE = 2'd1,
        MODE_RAMP    = 2'd2,
        MODE_HOLD    = 2'd3
    } mode_e;

    localparam logic [DATA_W-1:0] IMPULSE_VAL = 6'h1F;

    typedef enum logic [2:0] {
        GEN_IDLE,
        GEN_IMP,
        GEN_ZEROS,
        GEN_DONE,
        GEN_RAMP
    } gen_state_e;

endpackage

// File: rtl/fir_src_fifo.sv
// Show-ahead FIFO; head is visible on dout whenever not empty.
`timescale 1ns/1ps
module fir_src_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]       wr_q, wr_d;
    logic [AW:0]       rd_q, rd_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign level = wr_q - rd_q;
    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout  = mem_q[rd_q[AW-1:0]];

    // A pop frees the head slot, so a push into a full FIFO may proceed.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (do_push) begin
            mem_d[wr_q[AW-1:0]] = din;
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            mem_q <= '{default: '0};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/fir_axis_source.sv
// AXI-stream sample source for the FIR: pad capture FIFO or
// impulse/ramp generator, with overflow and transfer counters.
`timescale 1ns/1ps
module fir_axis_source
    import fir_stream_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int IMPULSE_ZEROS = 15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      pad_data,
    input  logic                   pad_strobe,
    input  logic [1:0]             mode,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [7:0]             sent_count
);
    localparam int ZW = $clog2(IMPULSE_ZEROS + 1);
    localparam logic [ZW-1:0] Z_LAST = ZW'(IMPULSE_ZEROS - 1);

    logic [2:0]        strobe_q, strobe_d;
    logic [DATA_W-1:0] d1_q, d1_d;
    logic [DATA_W-1:0] d2_q, d2_d;
    mode_e             mode_q, mode_d;
    gen_state_e        gen_state_q, gen_state_d;
    logic [DATA_W-1:0] gen_data_q, gen_data_d;
    logic [ZW-1:0]     zcnt_q, zcnt_d;
    logic              overflow_q, overflow_d;
    logic [7:0]        sent_q, sent_d;

    logic              xfer;
    logic              mode_ld;
    logic              mode_chg;
    logic              push;
    logic              in_pass;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_dout;
    logic              gen_valid;

    assign xfer    = m_axis_tvalid & m_axis_tready;
    assign mode_ld = ~m_axis_tvalid | xfer;
    assign mode_d  = mode_ld ? mode_e'(mode) : mode_q;
    assign mode_chg = (mode_d != mode_q);

    // Strobe edge detect after two sync stages; data rides alongside s2.
    assign strobe_d = {strobe_q[1:0], pad_strobe};
    assign d1_d     = pad_data;
    assign d2_d     = d1_q;
    assign push     = strobe_q[1] & ~strobe_q[2];

    assign in_pass   = (mode_q == MODE_PASS);
    assign fifo_push = push & in_pass;
    assign fifo_pop  = xfer & in_pass;

    assign overflow_d = overflow_q | (fifo_push & fifo_full & ~fifo_pop);
    assign sent_d     = xfer ? sent_q + 8'd1 : sent_q;

    assign gen_valid = (gen_state_q == GEN_IMP) ||
                       (gen_state_q == GEN_ZEROS) ||
                       (gen_state_q == GEN_RAMP);

    fir_src_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk  (clk),
        .reset(reset),
        .push (fifo_push),
        .pop  (fifo_pop),
        .din  (d2_q),
        .dout (fifo_dout),
        .empty(fifo_empty),
        .full (fifo_full),
        .level(fifo_level)
    );

    // Any accepted mode change re-seeds the generator for the new mode.
    always_comb begin
        gen_state_d = gen_state_q;
        gen_data_d  = gen_data_q;
        zcnt_d      = zcnt_q;
        if (mode_chg || gen_state_q == GEN_IDLE) begin
            zcnt_d = '0;
            unique case (mode_d)
                MODE_IMPULSE: begin
                    gen_state_d = GEN_IMP;
                    gen_data_d  = IMPULSE_VAL;
                end
                MODE_RAMP: begin
                    gen_state_d = GEN_RAMP;
                    gen_data_d  = '0;
                end
                default: begin
                    gen_state_d = GEN_IDLE;
                    gen_data_d  = '0;
                end
            endcase
        end else if (xfer) begin
            unique case (gen_state_q)
                GEN_IMP: begin
                    gen_state_d = GEN_ZEROS;
                    gen_data_d  = '0;
                    zcnt_d      = '0;
                end
                GEN_ZEROS: begin
                    if (zcnt_q == Z_LAST) begin
                        gen_state_d = GEN_DONE;
                    end else begin
                        zcnt_d = zcnt_q + ZW'(1);
                    end
                end
                GEN_RAMP: begin
                    gen_data_d = gen_data_q + DATA_W'(1);
                end
                default: begin
                    gen_state_d = gen_state_q;
                end
            endcase
        end
    end

    always_comb begin
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        unique case (mode_q)
            MODE_PASS: begin
                m_axis_tvalid = ~fifo_empty;
                m_axis_tdata  = fifo_empty ? '0 : fifo_dout;
            end
            MODE_IMPULSE, MODE_RAMP: begin
                m_axis_tvalid = gen_valid;
                m_axis_tdata  = gen_valid ? gen_data_q : '0;
            end
            MODE_HOLD: begin
                m_axis_tvalid = 1'b0;
            end
        endcase
    end

    assign overflow   = overflow_q;
    assign sent_count = sent_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            strobe_q    <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            mode_q      <= MODE_HOLD;
            gen_state_q <= GEN_IDLE;
            gen_data_q  <= '0;
            zcnt_q      <= '0;
            overflow_q  <= 1'b0;
            sent_q      <= '0;
        end else begin
            strobe_q    <= strobe_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            mode_q      <= mode_d;
            gen_state_q <= gen_state_d;
            gen_data_q  <= gen_data_d;
            zcnt_q      <= zcnt_d;
            overflow_q  <= overflow_d;
            sent_q      <= sent_d;
        end
    end

endmodule

// File: tb/tb_fir_axis_source.sv
// Scoreboard bench for fir_axis_source: expected samples are queued
// by the stimulus, a negedge monitor pops and compares on handshakes.
`timescale 1ns/1ps
module tb_fir_axis_source;
    import fir_stream_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] pad_data = '0;
    logic       pad_strobe = 1'b0;
    logic [1:0] mode = 2'd3;
    logic [5:0] tdata;
    logic       tvalid;
    logic       tready = 1'b0;
    logic       overflow;
    logic [2:0] fifo_level;
    logic [7:0] sent_count;

    int         n_pass = 0;
    int         n_checks = 0;
    logic [5:0] exp_q[$];
    int         n_exp = 0;
    logic       stall = 1'b0;
    logic [5:0] stall_data = '0;

    fir_axis_source #(
        .DEPTH(4),
        .IMPULSE_ZEROS(15)
    ) dut (
        .clk          (clk),
        .reset        (rst),
        .pad_data     (pad_data),
        .pad_strobe   (pad_strobe),
        .mode         (mode),
        .m_axis_tdata (tdata),
        .m_axis_tvalid(tvalid),
        .m_axis_tready(tready),
        .overflow     (overflow),
        .fifo_level   (fifo_level),
        .sent_count   (sent_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [5:0] v);
        exp_q.push_back(v);
        n_exp++;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() > 0; i++) tick();
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        exp_q.delete();
        n_exp = 0;
    endtask

    task automatic strobe_ignored(input logic [5:0] v);
        pad_data = v;
        repeat (3) tick();
        pad_strobe = 1'b1;
        repeat (4) tick();
        pad_strobe = 1'b0;
        repeat (3) tick();
    endtask

    // Monitor: compare every handshake against the queue, and check
    // that a stalled beat keeps tvalid and tdata until it is taken.
    always @(negedge clk) begin
        if (rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(tvalid), 32'd1);
                chk("hold_data", 32'(tdata), 32'(stall_data));
            end
            if (tvalid && tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_xfer: got %0h expected none",
                             tdata);
                end else begin
                    chk("xfer_data", 32'(tdata), 32'(exp_q.pop_front()));
                end
            end
            stall = tvalid && !tready;
            stall_data = tdata;
        end
    end

    initial begin
        int lvl;
        logic ovf;
        int quiet;
        logic [5:0] v;

        repeat (2) tick();
        chk("rst_tvalid", 32'(tvalid), 32'd0);
        chk("rst_tdata", 32'(tdata), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_sent", 32'(sent_count), 32'd0);
        rst = 1'b0;

        // single pad sample, latency from first sampling edge
        mode = MODE_PASS;
        tready = 1'b1;
        repeat (3) tick();
        pad_data = 6'h15;
        repeat (3) tick();
        pad_strobe = 1'b1;
        expect_val(6'h15);
        tick();
        tick();
        chk("t1_before_e2", 32'(tvalid), 32'd0);
        tick();
        chk("t1_valid_e2", 32'(tvalid), 32'd1);
        chk("t1_data", 32'(tdata), 32'h15);
        repeat (4) tick();
        pad_strobe = 1'b0;
        drain(20);
        repeat (4) tick();
        chk("t1_sent", 32'(sent_count), 32'd1);
        chk("t1_level", 32'(fifo_level), 32'd0);

        // overfill with sink stalled
        tready = 1'b0;
        lvl = 0;
        ovf = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            pad_data = 6'(s);
            repeat (3) tick();
            pad_strobe = 1'b1;
            if (lvl < 4) begin
                expect_val(6'(s));
                lvl++;
            end else begin
                ovf = 1'b1;
            end
            repeat (4) tick();
            pad_strobe = 1'b0;
            repeat (3) tick();
        end
        repeat (2) tick();
        chk("t2_level_full", 32'(fifo_level), 32'(lvl));
        chk("t2_overflow", 32'(overflow), 32'(ovf));
        tready = 1'b1;
        drain(40);
        repeat (3) tick();
        chk("t2_level_empty", 32'(fifo_level), 32'd0);
        chk("t2_overflow_sticky", 32'(overflow), 32'd1);
        chk("t2_sent", 32'(sent_count), 32'(8'(n_exp)));

        // impulse: one 0x1F then fifteen zeros, then silence
        reset_dut();
        mode = MODE_IMPULSE;
        tready = 1'b1;
        expect_val(IMPULSE_VAL);
        for (int z = 0; z < 15; z++) expect_val(6'h00);
        drain(100);
        quiet = 0;
        repeat (25) begin
            tick();
            if (tvalid) quiet++;
        end
        chk("t3_quiet", 32'(quiet), 32'd0);
        chk("t3_sent", 32'(sent_count), 32'd16);
        strobe_ignored(6'h2A);
        chk("t3_push_ignored", 32'(fifo_level), 32'd0);
        chk("t3_no_overflow", 32'(overflow), 32'd0);

        // ramp with random backpressure
        for (int r = 0; r < 66; r++) expect_val(6'(r % 64));
        tready = 1'b0;
        mode = MODE_RAMP;
        for (int c = 0; c < 2000 && exp_q.size() > 0; c++) begin
            tick();
            tready = (exp_q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        tready = 1'b0;
        chk("t4_drained", 32'(exp_q.size()), 32'd0);
        tick();
        chk("t4_next_valid", 32'(tvalid), 32'd1);
        chk("t4_next_data", 32'(tdata), 32'd2);

        // mode switch requested while a beat is pending
        mode = MODE_PASS;
        repeat (5) tick();
        chk("t5_held_valid", 32'(tvalid), 32'd1);
        chk("t5_held_data", 32'(tdata), 32'd2);
        expect_val(6'd2);
        tready = 1'b1;
        tick();
        chk("t5_pass_empty", 32'(tvalid), 32'd0);
        chk("t5_drained", 32'(exp_q.size()), 32'd0);

        // random pad samples in PASS with random backpressure
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                tready = ($urandom_range(0, 3) != 0);
                if (c == 0) begin
                    v = 6'($urandom);
                    pad_data = v;
                end
                if (c == 3) begin
                    pad_strobe = 1'b1;
                    expect_val(pad_data);
                end
                if (c == 5) pad_strobe = 1'b0;
            end
        end
        tready = 1'b1;
        drain(100);
        repeat (2) tick();
        chk("t7_no_overflow", 32'(overflow), 32'd0);
        chk("t7_sent", 32'(sent_count), 32'(8'(n_exp)));

        // reset while an impulse beat is stalled
        reset_dut();
        mode = MODE_IMPULSE;
        tready = 1'b1;
        expect_val(IMPULSE_VAL);
        for (int z = 0; z < 15; z++) expect_val(6'h00);
        for (int c = 0; c < 50 && exp_q.size() > 10; c++) tick();
        tready = 1'b0;
        tick();
        chk("t6_pending", 32'(tvalid), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_tvalid", 32'(tvalid), 32'd0);
        chk("t6_rst_sent", 32'(sent_count), 32'd0);
        chk("t6_rst_level", 32'(fifo_level), 32'd0);
        reset_dut();
        tready = 1'b1;
        expect_val(IMPULSE_VAL);
        for (int z = 0; z < 15; z++) expect_val(6'h00);
        drain(100);
        repeat (3) tick();
        chk("t6_sent", 32'(sent_count), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
